// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared types and constants for the data memory responder:
//               FSM state encoding, line offset width, default geometry and
//               latency counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    // 32-byte lines: byte offset lives in addr[4:0]
    localparam int LINE_OFFSET_W      = 5;
    localparam int DEFAULT_DATA_W     = 256;
    localparam int DEFAULT_DEPTH_LOG2 = 9;

    // Latency counter is wide enough for LATENCY up to 255
    localparam int CNT_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_memory_responder_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_ram
// Description : Single-port synchronous line store, DATA_W x 2^DEPTH_LOG2.
//               One write enable, registered read port (the read register
//               is the responder's read-data output and clears on reset;
//               the array itself is never reset).
// Ports       : clk, rst        - clock / async active-high reset
//               i_en            - access strobe
//               i_we            - 1 = write, 0 = read
//               i_addr          - line index
//               i_wdata         - write data
//               o_rdata         - registered read data, holds between reads
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram #(
    parameter int DATA_W     = 256,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    // Memory initialisation hook: r_mem is the preload target. Simulation
    // environments load line images into this array by hierarchical
    // reference before releasing reset; it has no reset of its own.
    logic [DATA_W-1:0] r_mem [0:c_depth-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only updates on a read, so a write leaves the last
    // read value visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Off-chip data memory model for the data cache refill /
//               write-back interface. One request at a time, acknowledged
//               with a one-cycle pulse LATENCY cycles after capture.
// Ports       : clk_i, rst_i    - clock / async active-high reset
//               mem_enable_i    - request valid
//               mem_write_i     - 1 = write line, 0 = read line
//               mem_addr_i      - byte address (bits [4:0] ignored)
//               mem_data_i      - write data
//               mem_data_o      - registered read data
//               mem_ack_o       - registered one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack_o
);

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_ack;

    logic [DEPTH_LOG2-1:0]   w_in_idx;
    logic                    w_ram_en;
    logic                    w_ram_we;
    logic [DEPTH_LOG2-1:0]   w_ram_idx;
    logic [DATA_W-1:0]       w_ram_wdata;
    logic                    w_unused_addr_bits;

    // Upper bits are dropped so the array aliases; offset bits are ignored.
    assign w_in_idx           = mem_addr_i[DEPTH_LOG2+LINE_OFFSET_W-1:LINE_OFFSET_W];
    assign w_unused_addr_bits = ^{mem_addr_i[ADDR_W-1:DEPTH_LOG2+LINE_OFFSET_W],
                                  mem_addr_i[LINE_OFFSET_W-1:0]};

    // Next state and RAM strobe. The RAM access happens on the edge that
    // enters ACK, so the read register is valid during the ack cycle.
    always_comb begin
        w_state_next = r_state;
        w_ram_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_enable_i) begin
                    if (LATENCY == 1) begin
                        w_state_next = ST_ACK;
                        w_ram_en     = 1'b1;
                    end else begin
                        w_state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_next = ST_ACK;
                    w_ram_en     = 1'b1;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // With LATENCY==1 the access fires on the capture edge itself, so the
    // live inputs feed the RAM while idle; otherwise the captured copy does.
    assign w_ram_we    = (r_state == ST_IDLE) ? mem_write_i : r_we;
    assign w_ram_idx   = (r_state == ST_IDLE) ? w_in_idx    : r_idx;
    assign w_ram_wdata = (r_state == ST_IDLE) ? mem_data_i  : r_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= (w_state_next == ST_ACK);
            case (r_state)
                ST_IDLE: begin
                    if (mem_enable_i) begin
                        r_we    <= mem_write_i;
                        r_idx   <= w_in_idx;
                        r_wdata <= mem_data_i;
                        r_cnt   <= c_cnt_load;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - c_cnt_one;
                end
                default: begin
                end
            endcase
        end
    end

    line_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_line_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_idx),
        .i_wdata (w_ram_wdata),
        .o_rdata (mem_data_o)
    );

    assign mem_ack_o = r_ack;

endmodule
`default_nettype wire
